mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Terminal stage of the stall-based address pipeline. Sits directly downstream of the last pipeline_stage.
//  Accepts one (address, id) beat and issues a single-outstanding read to memory.
//  Returns the data tagged with the original id/address to the result consumer.
//  Back-pressures the pipeline with out_stall while a transaction is in flight.
// PARAMETERS
//  ADDR_W          `ADDRESS_WIDTH  address width, matches pipeline
//  ID_W            `ID_WIDTH       transaction id width
//  DATA_W          32              memory read data width
//  TIMEOUT_CYCLES  16              WAIT cycles before forced completion (MEM_STAGE_TIMEOUT_EN only); >=1
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  in_address   in   ADDR_W  address from upstream stage
//  in_id        in   ID_W    id from upstream stage
//  in_valid     in   1       upstream beat valid
//  out_stall    out  1       to upstream in_stall; high = hold beat
//  mem_req      out  1       one-cycle read request pulse
//  mem_addr     out  ADDR_W  read address, stable from REQ until completion
//  mem_rvalid   in   1       read data valid; single-cycle pulse
//  mem_rdata    in   DATA_W  read data
//  res_valid    out  1       result valid
//  res_ready    in   1       consumer accepts result
//  res_id       out  ID_W    id of the completed beat
//  res_address  out  ADDR_W  address of the completed beat
//  res_data     out  DATA_W  captured read data
//  res_err      out  1       timeout completion flag
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0; captured address/id/data regs = 0.
//  - Transfer rule: a beat moves on a posedge when in_valid && !out_stall. The upstream stage holds while out_stall=1.
//  - out_stall = (state != IDLE). It is registered-state-derived only and has no combinational path from in_valid/res_ready.
//  - FSM:
//    - IDLE: on in_valid, capture in_address/in_id and go to REQ. Otherwise stay in IDLE.
//    - REQ: mem_req=1 for exactly this cycle, mem_addr=captured address. Next state is WAIT unconditionally.
//    - WAIT: on mem_rvalid, capture mem_rdata and go to RESP.
//    - RESP: res_valid=1, res_* stable. On res_ready go to IDLE; otherwise hold indefinitely.
//  - Latency: accept at edge N -> mem_req high in cycle N+1 -> res_valid earliest one cycle after the mem_rvalid edge.
//    - Zero-wait memory (mem_rvalid in the cycle after mem_req): res_valid in cycle N+3.
//  - Throughput: at most one beat per 4 cycles. A new beat is accepted no earlier than the cycle after RESP handshake.
//  - mem_rvalid outside WAIT is ignored, including a spurious pulse in the same cycle as REQ.
//  - mem_addr holds its last value in IDLE (no glitch requirement). mem_req is never high outside REQ.
//  - Reset mid-transaction drops the beat. No mem_req is reissued, and a late mem_rvalid is ignored.
// CONFIGURATION
//  MEM_STAGE_TIMEOUT_EN defined:
//    - Counter width is $clog2(TIMEOUT_CYCLES+1); it clears on entry to WAIT and increments each WAIT cycle without mem_rvalid.
//    - When count reaches TIMEOUT_CYCLES, go to RESP with res_data=0 and res_err=1.
//    - mem_rvalid in the same cycle as the timeout wins: normal data, res_err=0.
//    - res_err clears on the RESP handshake.
//  MEM_STAGE_TIMEOUT_EN undefined:
//    - No counter; WAIT waits forever; res_err tied 0.
// STRUCTURE
//  - mem_stage_pkg: typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_state_t; the state encoding and the counter-width function.
//  - Single module; no sub-module.
//  - Timeout counter lives inline under `ifdef.
// TESTING
//  1. Reset: assert reset mid-WAIT -> out_stall=0, mem_req=0, res_valid=0 next cycle. A later mem_rvalid produces no result.
//  2. Single beat: addr=0x12, id=3, rvalid with data 0xDEADBEEF two cycles after req.
//     -> one mem_req with mem_addr=0x12; res_id=3, res_address=0x12, res_data=0xDEADBEEF.
//  3. Back-pressure: continuous upstream valid, res_ready held 0 for 10 cycles.
//     -> out_stall stays 1; res_* stable; no second mem_req.
//  4. Zero-wait memory with ids 1,2,3 back-to-back and res_ready=1 -> results appear in order 1,2,3, spaced 4 cycles apart.
//  5. Spurious rvalid during IDLE and during REQ -> ignored; the result carries the later, genuine data.
//  6. (MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4) no rvalid -> res_valid with res_err=1, res_data=0 after 4 WAIT cycles.
//     - Repeat with rvalid exactly on the 4th WAIT cycle -> res_err=0, data taken.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory access stage: FSM state
// encoding, default widths and the timeout counter width function.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    localparam int DEF_ADDR_W = `ADDRESS_WIDTH;
    localparam int DEF_ID_W   = `ID_WIDTH;

    // Width needed to hold the values 0..cycles inclusive.
    function automatic int timeout_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// Terminal stage of the stall-based address pipeline. Takes one
// (address, id) beat, issues a single-outstanding memory read and hands
// the tagged result to the consumer, stalling upstream meanwhile.
// Optional build macro: MEM_STAGE_TIMEOUT_EN enables a WAIT timeout that
// forces completion with res_err=1 and res_data=0.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ID_W           = DEF_ID_W,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_valid,
    output logic              out_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ID_W-1:0]   res_id,
    output logic [ADDR_W-1:0] res_address,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err
);

    mem_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                stall_q, stall_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                err_q, err_d;
`endif

    // Next-state, capture and registered-output decode for the FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        data_d  = data_q;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
        cnt_inc_s = cnt_q + CNT_W'(1);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d  = in_address;
                    id_d    = in_id;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Any rvalid seen here belongs to nobody and is dropped.
                state_d = WAIT;
`ifdef MEM_STAGE_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT: begin
                // Genuine data beats a simultaneous timeout.
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = RESP;
`ifdef MEM_STAGE_TIMEOUT_EN
                    err_d = 1'b0;
                end else if (cnt_inc_s == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = WAIT;
                end
`else
                end else begin
                    state_d = WAIT;
                end
`endif
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs follow the next state so they are glitch-free flops.
        stall_d = (state_d != IDLE);
        req_d   = (state_d == REQ);
        valid_d = (state_d == RESP);
    end

    // State and capture registers; reset drops any in-flight beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            data_q  <= '0;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            req_q   <= req_d;
            valid_q <= valid_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign out_stall   = stall_q;
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign res_valid   = valid_q;
    assign res_id      = id_q;
    assign res_address = addr_q;
    assign res_data    = data_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    assign res_err     = err_q;
`else
    assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected results are queued as
// beats are driven and compared at each result handshake.
module tb_mem_access_stage;

    localparam int AW = 16;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_address;
    logic [IW-1:0] in_id;
    logic          in_valid;
    logic          out_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_id;
    logic [AW-1:0] res_address;
    logic [DW-1:0] res_data;
    logic          res_err;

    mem_access_stage #(
        .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .out_stall(out_stall),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_address(res_address),
        .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          sb_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            req_count = 0;
    int            exp_reqs = 0;
    logic          prev_req = 1'b0;
    int            hs_cyc[$];
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] resp_addr;
    logic          mem_enable = 1'b0;
    int            mem_lat = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        logic [31:0] d;
        d = 32'(a ^ 16'h0012);
        return 32'hDEADBEEF ^ (d * 32'h0100_0193);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Request / result monitor.
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (mem_req) begin
                req_count++;
                check("mem_req_single_pulse", prev_req, 1'b0);
                check("mem_addr", mem_addr, last_addr);
            end
            prev_req = mem_req;
            if (res_valid && res_ready) begin
                hs_cyc.push_back(cyc);
                check("sb_nonempty", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    check("res_id", res_id, sb_e.id);
                    check("res_address", res_address, sb_e.addr);
                    check("res_data", res_data, sb_e.data);
                    check("res_err", res_err, sb_e.err);
                end
            end
        end
    end

    // Memory responder: rvalid mem_lat cycles after the request cycle.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_enable && mem_req && !reset) begin
                resp_addr = mem_addr;
                repeat (mem_lat) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = model_data(resp_addr);
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h5A5A_5A5A;
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id, input bit push,
                        input logic [DW-1:0] d, input logic e, output int acc_c);
        bit ok;
        ok = 1'b0;
        in_address = a;
        in_id      = id;
        in_valid   = 1'b1;
        if (push) sb_q.push_back('{id, a, d, e});
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!out_stall) ok = 1'b1;
            else @(negedge clk);
        end
        check("accept_in_time", ok, 1'b1);
        @(posedge clk);
        last_addr = a;
        exp_reqs++;
        #1;
        acc_c    = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, base, rc, nhs;
        reset = 1'b1; in_valid = 1'b0; in_address = '0; in_id = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_stall", out_stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_address", res_address, 16'h0);
        check("rst_res_id", res_id, 4'h0);
        check("rst_mem_addr", mem_addr, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single beat, rvalid two cycles after the request.
        mem_enable = 1'b1; mem_lat = 2; res_ready = 1'b1;
        base = hs_cyc.size();
        send(16'h0012, 4'd3, 1'b1, 32'hDEADBEEF, 1'b0, acc);
        drain(50);
        if (hs_cyc.size() > base) check("single_latency", hs_cyc[base] - acc, 3);
        check("single_req_count", req_count, 1);

        // Zero-wait memory, ids 1,2,3 back to back.
        mem_lat = 1;
        base = hs_cyc.size();
        for (int k = 1; k <= 3; k++) begin
            send(16'h0100 + 16'(k * 4), 4'(k), 1'b1, model_data(16'h0100 + 16'(k * 4)), 1'b0, acc);
            if (k == 1) acc1 = acc;
        end
        drain(50);
        if (hs_cyc.size() >= base + 3) begin
            check("zw_first_latency", hs_cyc[base] - acc1, 2);
            check("zw_spacing_12", hs_cyc[base + 1] - hs_cyc[base], 4);
            check("zw_spacing_23", hs_cyc[base + 2] - hs_cyc[base + 1], 4);
        end
        check("zw_result_count", hs_cyc.size() - base, 3);

        // Back-pressure with a second beat waiting upstream.
        res_ready = 1'b0;
        send(16'h0200, 4'd5, 1'b1, model_data(16'h0200), 1'b0, acc);
        in_address = 16'h0300; in_id = 4'd6; in_valid = 1'b1;
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        rc = req_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_stall", out_stall, 1'b1);
            check("bp_res_valid", res_valid, 1'b1);
            check("bp_res_id", res_id, 4'd5);
            check("bp_res_address", res_address, 16'h0200);
            check("bp_res_data", res_data, model_data(16'h0200));
        end
        check("bp_no_second_req", req_count, rc);
        res_ready = 1'b1;
        send(16'h0300, 4'd6, 1'b1, model_data(16'h0300), 1'b0, acc);
        drain(50);

        // Spurious rvalid during IDLE and during REQ.
        mem_enable = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0001;
        @(negedge clk);
        mem_rvalid = 1'b0;
        send(16'h0400, 4'd7, 1'b1, 32'hC0FF_EE00, 1'b0, acc);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0002;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk); @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hC0FF_EE00;
        @(negedge clk);
        mem_rvalid = 1'b0;
        drain(50);

        // Reset while waiting for memory drops the beat.
        nhs = hs_cyc.size();
        send(16'h0500, 4'd9, 1'b0, 32'h0, 1'b0, acc);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_out_stall", out_stall, 1'b0);
        check("rstw_mem_req", mem_req, 1'b0);
        check("rstw_res_valid", res_valid, 1'b0);
        reset = 1'b0;
        rc = req_count;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hBAAD_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (6) @(negedge clk);
        check("rstw_late_res_valid", res_valid, 1'b0);
        check("rstw_late_out_stall", out_stall, 1'b0);
        check("rstw_no_result", hs_cyc.size(), nhs);
        check("rstw_no_reissue", req_count, rc);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Timeout with no rvalid, then rvalid exactly on the last WAIT cycle.
        mem_enable = 1'b0;
        base = hs_cyc.size();
        send(16'h0600, 4'd10, 1'b1, 32'h0, 1'b1, acc);
        drain(50);
        if (hs_cyc.size() > base) check("to_latency", hs_cyc[base] - acc, 5);
        @(negedge clk);
        check("to_err_cleared", res_err, 1'b0);
        mem_enable = 1'b1; mem_lat = 4;
        base = hs_cyc.size();
        send(16'h0700, 4'd11, 1'b1, model_data(16'h0700), 1'b0, acc);
        drain(50);
        if (hs_cyc.size() > base) check("to_edge_latency", hs_cyc[base] - acc, 5);
        mem_enable = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("req_total", req_count, exp_reqs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
